// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin arbiter that lends one shared interval counter to
// several requesters, sequencing the counter through reset/start/overflow.
// Optional feature: define TIMER_ARBITER_TIMEOUT_EN to abandon a grant when the
// counter never reports counting within 8 cycles of START.
//
// state   | meaning
// IDLE    | no grant, waiting for any request
// LOAD    | grant issued, counter held in reset for one cycle
// START   | counter_start held until the counter reports counting
// RUN     | waiting for the overflow edge or a request withdrawal
// RELEASE | one-cycle gap; grant low, last-served index updated
module timer_arbiter #(
  parameter int requesters = 4,
  parameter int bitwidth   = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [requesters-1:0]          request,
  input  logic [requesters*bitwidth-1:0] duration,
  output logic [requesters-1:0]          grant,
  output logic [requesters-1:0]          done,
  output logic                           busy,
  output logic                           counter_reset,
  output logic                           counter_start,
  output logic                           counter_stop,
  output logic [bitwidth-1:0]            counter_tick_count_overflow,
  input  logic                           counter_counting,
  input  logic                           counter_overflow,
  output logic                           timeout
);

  localparam int IDXW = (requesters > 1) ? $clog2(requesters) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [IDXW-1:0]     last_q, last_d;
  logic                ovf_prev_q;
  logic [requesters-1:0] grant_q, grant_d, done_q, done_d;
  logic                busy_q, busy_d;
  logic                counter_reset_q, counter_reset_d;
  logic                counter_start_q, counter_start_d;
  logic                counter_stop_q, counter_stop_d;
  logic [bitwidth-1:0] tick_q, tick_d;

  logic [IDXW-1:0]     base;
  logic [IDXW-1:0]     sel;
  logic [bitwidth-1:0] dur_sel;
  logic                found;
  int                  cand;
  logic                pick;
  logic                complete;
  logic                abort;
  logic                tmo_fire;
  logic                ovf_edge;

`ifdef TIMER_ARBITER_TIMEOUT_EN
  logic [3:0] tmr_q, tmr_d;
  logic       timeout_q;
`endif

  // State and output registers; counter_reset is held asserted during reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      last_q          <= IDXW'(requesters - 1);
      ovf_prev_q      <= 1'b0;
      grant_q         <= '0;
      done_q          <= '0;
      busy_q          <= 1'b0;
      counter_reset_q <= 1'b1;
      counter_start_q <= 1'b0;
      counter_stop_q  <= 1'b0;
      tick_q          <= '0;
`ifdef TIMER_ARBITER_TIMEOUT_EN
      tmr_q           <= '0;
      timeout_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      last_q          <= last_d;
      ovf_prev_q      <= counter_overflow;
      grant_q         <= grant_d;
      done_q          <= done_d;
      busy_q          <= busy_d;
      counter_reset_q <= counter_reset_d;
      counter_start_q <= counter_start_d;
      counter_stop_q  <= counter_stop_d;
      tick_q          <= tick_d;
`ifdef TIMER_ARBITER_TIMEOUT_EN
      tmr_q           <= tmr_d;
      timeout_q       <= tmo_fire;
`endif
    end
  end

  // Next state: round-robin pick (also from RELEASE so the grant gap is one
  // cycle), abort on withdrawal, completion on the overflow rising edge.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    pick     = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    tmo_fire = 1'b0;
    found    = 1'b0;
    sel      = '0;
    cand     = 0;
    base     = last_q;
`ifdef TIMER_ARBITER_TIMEOUT_EN
    tmr_d    = tmr_q;
`endif
    if (state_q == RELEASE) begin
      base   = idx_q;
      last_d = idx_q;
    end
    for (int k = 1; k <= requesters; k++) begin
      cand = int'(base) + k;
      if (cand >= requesters) cand = cand - requesters;
      if (!found && request[cand]) begin
        found = 1'b1;
        sel   = IDXW'(cand);
      end
    end
    dur_sel  = duration[int'(sel)*bitwidth +: bitwidth];
    ovf_edge = counter_overflow & ~ovf_prev_q;

    case (state_q)
      IDLE, RELEASE: begin
        if (found) begin
          pick  = 1'b1;
          idx_d = sel;
          if (dur_sel == '0) begin
            complete = 1'b1;
            state_d  = RELEASE;
          end else begin
            state_d  = LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
`ifdef TIMER_ARBITER_TIMEOUT_EN
        tmr_d = 4'd8;
`endif
        if (!request[idx_q]) begin
          abort   = 1'b1;
          state_d = RELEASE;
        end else begin
          state_d = START;
        end
      end
      START: begin
        if (!request[idx_q]) begin
          abort   = 1'b1;
          state_d = RELEASE;
        end else if (counter_counting) begin
          state_d = RUN;
`ifdef TIMER_ARBITER_TIMEOUT_EN
        end else if (tmr_q == 4'd0) begin
          tmo_fire = 1'b1;
          state_d  = RELEASE;
        end else begin
          tmr_d = tmr_q - 4'd1;
`endif
        end
      end
      RUN: begin
        // A simultaneous overflow edge and withdrawal still counts as done.
        if (ovf_edge) begin
          complete = 1'b1;
          state_d  = RELEASE;
        end else if (!request[idx_q]) begin
          abort   = 1'b1;
          state_d = RELEASE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state and transition flags.
  always_comb begin
    grant_d = '0;
    if (state_d == LOAD || state_d == START || state_d == RUN) grant_d[idx_d] = 1'b1;
    done_d = '0;
    if (complete) done_d[idx_d] = 1'b1;
    busy_d          = (state_d != IDLE);
    counter_reset_d = (state_d == LOAD);
    counter_start_d = (state_d == START);
    // Stop pulse lands on the first RELEASE cycle of an abandoned grant.
    counter_stop_d  = abort | tmo_fire;
    tick_d = tick_q;
    if (pick) tick_d = dur_sel;
    else if (state_d == IDLE) tick_d = '0;
  end

  assign grant                       = grant_q;
  assign done                        = done_q;
  assign busy                        = busy_q;
  assign counter_reset               = counter_reset_q;
  assign counter_start               = counter_start_q;
  assign counter_stop                = counter_stop_q;
  assign counter_tick_count_overflow = tick_q;
`ifdef TIMER_ARBITER_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  request;
  logic [31:0] duration;
  logic [3:0]  grant, done;
  logic        busy, counter_reset, counter_start, counter_stop, timeout;
  logic [7:0]  counter_tick_count_overflow;
  logic        counter_counting, counter_overflow;
  logic        counting_block;

  logic [7:0]  cm_cnt;
  logic        cm_counting, cm_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  timer_arbiter #(.requesters(4), .bitwidth(8)) dut (
    .clock(clock), .reset(reset), .request(request), .duration(duration),
    .grant(grant), .done(done), .busy(busy),
    .counter_reset(counter_reset), .counter_start(counter_start),
    .counter_stop(counter_stop),
    .counter_tick_count_overflow(counter_tick_count_overflow),
    .counter_counting(counter_counting), .counter_overflow(counter_overflow),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Simple interval counter: reset/start/stop, overflow after N counting cycles.
  always @(posedge clock) begin
    if (counter_reset) begin
      cm_cnt <= 8'd0; cm_counting <= 1'b0; cm_ovf <= 1'b0;
    end else if (counter_stop) begin
      cm_counting <= 1'b0;
    end else if (counter_start && !cm_counting && !cm_ovf) begin
      cm_counting <= 1'b1; cm_cnt <= 8'd0;
    end else if (cm_counting) begin
      if (cm_cnt + 8'd1 == counter_tick_count_overflow) begin
        cm_ovf <= 1'b1; cm_counting <= 1'b0;
      end else begin
        cm_cnt <= cm_cnt + 8'd1;
      end
    end
  end

  assign counter_counting = cm_counting & ~counting_block;
  assign counter_overflow = cm_ovf;

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic do_reset;
    reset = 1'b1; request = 4'b0; duration = 32'b0; counting_block = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; request = 4'b0; duration = 32'b0; counting_block = 1'b0;
    tick; tick;
    n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant got %b want 0000", grant); end
    n_cmp++; if (done !== 4'b0) begin n_bad++; $display("FAIL reset_done got %b want 0000", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (counter_reset !== 1'b1) begin n_bad++; $display("FAIL reset_creset got %b want 1", counter_reset); end
    n_cmp++; if (counter_start !== 1'b0 || counter_stop !== 1'b0) begin n_bad++; $display("FAIL reset_start_stop got %b%b want 00", counter_start, counter_stop); end
    n_cmp++; if (counter_tick_count_overflow !== 8'd0) begin n_bad++; $display("FAIL reset_ovfval got %0d want 0", counter_tick_count_overflow); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got %b want 0", timeout); end
    reset = 1'b0;
    tick;
    n_cmp++; if (counter_reset !== 1'b0) begin n_bad++; $display("FAIL idle_creset got %b want 0", counter_reset); end
  endtask

  task automatic test_single;
    int cyc;
    logic got;
    do_reset;
    request = 4'b0001; duration[7:0] = 8'd10;
    tick;
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL single_grant got %b want 0001", grant); end
    n_cmp++; if (counter_reset !== 1'b1) begin n_bad++; $display("FAIL single_load_creset got %b want 1", counter_reset); end
    n_cmp++; if (counter_tick_count_overflow !== 8'd10) begin n_bad++; $display("FAIL single_ovfval got %0d want 10", counter_tick_count_overflow); end
    duration[7:0] = 8'd99;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      tick; cyc++;
      if (done !== 4'b0) got = 1'b1;
    end
    n_cmp++; if (!got || done !== 4'b0001) begin n_bad++; $display("FAIL single_done got %b want 0001", done); end
    n_cmp++; if (cyc < 12 || cyc > 16) begin n_bad++; $display("FAIL single_latency got %0d want 12..16", cyc); end
    n_cmp++; if (counter_tick_count_overflow !== 8'd10) begin n_bad++; $display("FAIL single_ovfval_held got %0d want 10", counter_tick_count_overflow); end
    request = 4'b0;
    tick;
    n_cmp++; if (grant !== 4'b0 || done !== 4'b0) begin n_bad++; $display("FAIL single_after got grant %b done %b want 0000 0000", grant, done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_round_robin;
    int k, gap, cyc;
    logic [3:0] prev, exp_g;
    do_reset;
    duration = {4{8'd3}}; request = 4'hF;
    k = 0; gap = 0; cyc = 0; prev = 4'b0;
    while (k < 5 && cyc < 200) begin
      tick; cyc++;
      n_cmp++; if ($countones(grant) > 1 || $countones(done) > 1) begin n_bad++; $display("FAIL rr_onehot got grant %b done %b", grant, done); end
      if (grant != 4'b0 && prev == 4'b0) begin
        exp_g = 4'b0001 << (k % 4);
        n_cmp++; if (grant !== exp_g) begin n_bad++; $display("FAIL rr_order[%0d] got %b want %b", k, grant, exp_g); end
        if (k > 0) begin
          n_cmp++; if (gap != 1) begin n_bad++; $display("FAIL rr_gap[%0d] got %0d want 1", k, gap); end
        end
        k++; gap = 0;
      end
      if (grant == 4'b0) gap++;
      prev = grant;
    end
    n_cmp++; if (k != 5) begin n_bad++; $display("FAIL rr_count got %0d want 5", k); end
    request = 4'b0;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 30) begin tick; cyc++; end
  endtask

  task automatic test_zero;
    int n_done;
    logic saw_start, bad_bit;
    do_reset;
    request = 4'b0100;
    n_done = 0; saw_start = 1'b0; bad_bit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (counter_start) saw_start = 1'b1;
      if (done == 4'b0100) begin n_done++; request = 4'b0; end
      else if (done != 4'b0) bad_bit = 1'b1;
    end
    n_cmp++; if (n_done != 1 || bad_bit) begin n_bad++; $display("FAIL zero_done got %0d pulses (stray %b) want 1", n_done, bad_bit); end
    n_cmp++; if (saw_start !== 1'b0) begin n_bad++; $display("FAIL zero_start got %b want 0", saw_start); end
  endtask

  task automatic test_abort;
    int n;
    do_reset;
    duration[15:8] = 8'd50; request = 4'b0010;
    n = 0; while (counter_start !== 1'b1 && n < 10) begin tick; n++; end
    n_cmp++; if (n >= 10) begin n_bad++; $display("FAIL abort_start got timeout want counter_start"); end
    n = 0; while (counter_start !== 1'b0 && n < 10) begin tick; n++; end
    n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL abort_run_grant got %b want 0010", grant); end
    repeat (4) tick;
    request = 4'b0;
    tick;
    n_cmp++; if (counter_stop !== 1'b1) begin n_bad++; $display("FAIL abort_stop got %b want 1", counter_stop); end
    n_cmp++; if (done !== 4'b0 || grant !== 4'b0) begin n_bad++; $display("FAIL abort_release got done %b grant %b want 0000 0000", done, grant); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy1 got %b want 1", busy); end
    tick;
    n_cmp++; if (busy !== 1'b0 || counter_stop !== 1'b0 || done !== 4'b0) begin n_bad++; $display("FAIL abort_idle got busy %b stop %b done %b want 0 0 0000", busy, counter_stop, done); end
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset;
    duration[7:0] = 8'd20; request = 4'b0001;
    n = 0; while (counter_start !== 1'b1 && n < 10) begin tick; n++; end
    n = 0; while (counter_start !== 1'b0 && n < 10) begin tick; n++; end
    repeat (3) tick;
    reset = 1'b1;
    #1;
    n_cmp++; if (grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset got grant %b done %b busy %b want 0", grant, done, busy); end
    n_cmp++; if (counter_start !== 1'b0 || counter_stop !== 1'b0 || counter_tick_count_overflow !== 8'd0) begin n_bad++; $display("FAIL mid_reset_ctl got %b %b %0d want 0 0 0", counter_start, counter_stop, counter_tick_count_overflow); end
    n_cmp++; if (counter_reset !== 1'b1) begin n_bad++; $display("FAIL mid_reset_creset got %b want 1", counter_reset); end
    request = 4'b0;
    tick;
    reset = 1'b0; request = 4'b1000; duration[31:24] = 8'd4;
    tick;
    n_cmp++; if (grant !== 4'b1000) begin n_bad++; $display("FAIL mid_regrant got %b want 1000", grant); end
    n = 0; while (done === 4'b0 && n < 30) begin tick; n++; end
    n_cmp++; if (done !== 4'b1000) begin n_bad++; $display("FAIL mid_done got %b want 1000", done); end
    request = 4'b0;
    tick; tick;
  endtask

  task automatic test_start_timeout;
    int n, seen;
    logic bad_done;
    do_reset;
    counting_block = 1'b1; duration[7:0] = 8'd5; request = 4'b0001;
    n = 0; while (counter_start !== 1'b1 && n < 10) begin tick; n++; end
    n_cmp++; if (n >= 10) begin n_bad++; $display("FAIL tmo_start got timeout want counter_start"); end
    seen = -1; bad_done = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (timeout === 1'b1 && seen < 0) begin
        seen = i;
        n_cmp++; if (counter_stop !== 1'b1) begin n_bad++; $display("FAIL tmo_stop got %b want 1", counter_stop); end
      end
      if (done !== 4'b0) bad_done = 1'b1;
    end
`ifdef TIMER_ARBITER_TIMEOUT_EN
    n_cmp++; if (seen != 9) begin n_bad++; $display("FAIL tmo_cycle got %0d want 9", seen); end
`else
    n_cmp++; if (seen != -1) begin n_bad++; $display("FAIL tmo_absent got %0d want -1", seen); end
    n_cmp++; if (busy !== 1'b1 || counter_start !== 1'b1) begin n_bad++; $display("FAIL tmo_wait got busy %b start %b want 1 1", busy, counter_start); end
`endif
    n_cmp++; if (bad_done !== 1'b0) begin n_bad++; $display("FAIL tmo_done got %b want 0", bad_done); end
    do_reset;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_zero;
    test_abort;
    test_reset_mid;
    test_start_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL have parameter requesters, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter bitwidth, default 8, width of durations and counter overflow value.
REQ-003 SHALL have port clock  in  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port request  in  requesters  per-requester level request, held high until done.
REQ-006 SHALL have port duration  in  requesters*bitwidth  tick count of requester i at bits [i*bitwidth +: bitwidth].
REQ-007 SHALL have port grant  out  requesters  one-hot owner of the shared counter.
REQ-008 SHALL have port done  out  requesters  one-cycle pulse when the granted interval elapsed.
REQ-009 SHALL have port busy  out  1  high in any state except IDLE.
REQ-010 SHALL have port counter_reset  out  1  drives the counter's reset.
REQ-011 SHALL have port counter_start  out  1  drives the counter's start.
REQ-012 SHALL have port counter_stop  out  1  drives the counter's stop.
REQ-013 SHALL have port counter_tick_count_overflow  out  bitwidth  drives the counter's overflow value.
REQ-014 SHALL have port counter_counting  in  1  the counter's counting flag.
REQ-015 SHALL have port counter_overflow  in  1  the counter's overflow flag.
REQ-016 SHALL have port timeout  out  1  one-cycle error pulse (see Configuration).

Function
REQ-017 SHALL implement states IDLE, LOAD, START, RUN, RELEASE; all outputs registered.
REQ-018 IDLE: on any request high, SHALL select round-robin the first requester after the last-served index (wrapping), latch its index and duration, assert grant, go LOAD next cycle.
REQ-019 IDLE with latched duration zero SHALL skip the counter: pulse done for that requester in the same transition, go RELEASE.
REQ-020 LOAD: SHALL assert counter_reset for exactly one cycle; counter_tick_count_overflow SHALL hold the latched duration from LOAD until RELEASE exit; then go START.
REQ-021 START: SHALL hold counter_start high until counter_counting is sampled high, then drop it and go RUN.
REQ-022 RUN: SHALL detect a rising edge of counter_overflow (registered previous value), pulse done of the granted requester, go RELEASE.
REQ-023 Granted request dropping in LOAD, START or RUN SHALL abort: counter_stop high one cycle, no done, go RELEASE.
REQ-024 Overflow edge and request withdrawal in the same cycle SHALL count as completion: done pulses, no counter_stop.
REQ-025 RELEASE: grant, counter_start and counter_stop SHALL be low; last-served index SHALL update to the granted index; return to IDLE next cycle.
REQ-026 Minimum gap between consecutive grants SHALL be one cycle (RELEASE); duration changes while granted SHALL be ignored.
REQ-027 done SHALL be zero except for the single-cycle pulse; at most one bit of grant and done high at any time.

Reset
REQ-028 On reset high: state IDLE, last-served index requesters-1 (first grant goes to requester 0), grant, done, busy, counter_start, counter_stop, timeout, counter_tick_count_overflow all 0; counter_reset SHALL be 1 while reset is high.
REQ-029 Reset mid-operation SHALL abandon the grant with no done pulse; operation resumes from IDLE on the first clock after release.

Configuration
REQ-030 Macro TIMER_ARBITER_TIMEOUT_EN defined: if counter_counting is not seen within 8 cycles in START, SHALL pulse timeout one cycle, assert counter_stop one cycle, issue no done, go RELEASE.
REQ-031 Macro undefined: START SHALL wait indefinitely; timeout SHALL be constant 0.

Verification
REQ-032 Bench with counter (bitwidth 8) connected: request[0]=1, duration0=10 -> grant=0001 next cycle, one done[0] pulse 12..16 cycles after grant, grant clears the cycle after.
REQ-033 request=1111 held, all durations 3 -> grants in order 0,1,2,3,0, each separated by exactly one RELEASE cycle.
REQ-034 request[2]=1, duration2=0 -> done[2] pulses, counter_start never asserts.
REQ-035 request[1] dropped 5 cycles into RUN with duration1=50 -> counter_stop one cycle, no done[1], busy low two cycles later.
REQ-036 reset asserted during RUN -> all outputs 0 same cycle; counter_reset 1; after release, request[3] alone granted normally.
REQ-037 With TIMER_ARBITER_TIMEOUT_EN, counter_counting tied 0 -> timeout pulses 9 cycles after START entry, no done; without it, busy stays high.
